// File: rtl/seq_divider.sv
// seq_divider: iterative radix-2 restoring divider for DIV/DIVU/REM/REMU (XLEN-bit).
// Latency: XLEN+1 cycles from accept to out_valid (divide-by-zero / signed overflow: 1 cycle).
// Backpressure: result held in DONE until out_ready; in_ready low while busy; kill aborts any state.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake; op_signed, op_rem, dividend, divisor sampled at accept
//   kill                  synchronous abort, wins over accept and the result handshake
//   out_valid / out_ready result handshake; result and div_zero are stable while out_valid
// Optional build macro SEQ_DIVIDER_WORD_EN adds word_op (32-bit *W variants, 32 iterations).
module seq_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            op_signed,
  input  logic            op_rem,
`ifdef SEQ_DIVIDER_WORD_EN
  input  logic            word_op,
`endif
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            kill,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            div_zero
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_op_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;
  logic            r_div_zero;

  // Effective operands, most-negative value and iteration count for this request.
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_min;
  logic [CW-1:0]   w_iters;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic [XLEN-1:0] w_quo_init;
  logic            w_a_neg;
  logic            w_b_neg;
  logic            w_b_zero;
  logic            w_ovf;
  logic [XLEN-1:0] w_spec_res;
  logic [XLEN-1:0] w_spec_out;

  // One restoring step.
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_trial;
  logic            w_ge;
  logic [XLEN-1:0] w_quo_nxt;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_calc_res;
  logic [XLEN-1:0] w_calc_out;

  logic            w_accept;
  logic            w_last;

`ifdef SEQ_DIVIDER_WORD_EN
  logic            r_word;

  assign w_a = !word_op ? dividend :
               op_signed ? {{(XLEN-32){dividend[31]}}, dividend[31:0]} :
                           {{(XLEN-32){1'b0}}, dividend[31:0]};
  assign w_b = !word_op ? divisor :
               op_signed ? {{(XLEN-32){divisor[31]}}, divisor[31:0]} :
                           {{(XLEN-32){1'b0}}, divisor[31:0]};
  // 0x80000000 sign-extended, so the overflow compare works on the extended operand.
  assign w_min   = word_op ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
  assign w_iters = word_op ? CW'(32) : CW'(XLEN);
  // Word magnitudes fit in 32 bits; park them in the upper half so 32 shifts consume them.
  assign w_quo_init = word_op ? (w_a_mag << 32) : w_a_mag;
  assign w_spec_out = word_op ? {{(XLEN-32){w_spec_res[31]}}, w_spec_res[31:0]} : w_spec_res;
  assign w_calc_out = r_word ? {{(XLEN-32){w_calc_res[31]}}, w_calc_res[31:0]} : w_calc_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= 1'b0;
    end else if (w_accept) begin
      r_word <= word_op;
    end
  end
`else
  assign w_a        = dividend;
  assign w_b        = divisor;
  assign w_min      = {1'b1, {(XLEN-1){1'b0}}};
  assign w_iters    = CW'(XLEN);
  assign w_quo_init = w_a_mag;
  assign w_spec_out = w_spec_res;
  assign w_calc_out = w_calc_res;
`endif

  assign w_a_neg  = op_signed & w_a[XLEN-1];
  assign w_b_neg  = op_signed & w_b[XLEN-1];
  assign w_a_mag  = w_a_neg ? -w_a : w_a;
  assign w_b_mag  = w_b_neg ? -w_b : w_b;
  assign w_b_zero = (w_b == {XLEN{1'b0}});
  assign w_ovf    = op_signed & (w_a == w_min) & (w_b == {XLEN{1'b1}});

  // Divide-by-zero: q = all ones, r = dividend. Overflow: q = dividend, r = 0.
  assign w_spec_res = w_b_zero ? (op_rem ? w_a : {XLEN{1'b1}}) :
                                 (op_rem ? {XLEN{1'b0}} : w_a);

  // Shifted partial remainder can reach 2*|B|-1, hence the extra bit; bit XLEN of
  // the trial difference is its sign.
  assign w_shift    = {r_rem, r_quo[XLEN-1]};
  assign w_trial    = w_shift - {1'b0, r_div};
  assign w_ge       = ~w_trial[XLEN];
  assign w_quo_nxt  = {r_quo[XLEN-2:0], w_ge};
  assign w_rem_nxt  = w_ge ? w_trial[XLEN-1:0] : w_shift[XLEN-1:0];
  assign w_quo_fix  = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix  = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_calc_res = r_op_rem ? w_rem_fix : w_quo_fix;

  assign w_accept = in_valid & (r_state == IDLE) & ~kill;
  assign w_last   = (r_state == CALC) & (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (kill) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (in_valid) w_state_nxt = (w_b_zero || w_ovf) ? DONE : CALC;
        CALC:    if (w_last) w_state_nxt = DONE;
        DONE:    if (out_ready) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem      <= '0;
      r_quo      <= '0;
      r_div      <= '0;
      r_cnt      <= '0;
      r_op_rem   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_rem    <= '0;
      r_quo    <= w_quo_init;
      r_div    <= w_b_mag;
      r_cnt    <= w_iters;
      r_op_rem <= op_rem;
      r_neg_q  <= w_a_neg ^ w_b_neg;
      r_neg_r  <= w_a_neg;
      if (w_b_zero || w_ovf) begin
        r_result   <= w_spec_out;
        r_div_zero <= w_b_zero;
      end
    end else if (r_state == CALC && !kill) begin
      r_rem <= w_rem_nxt;
      r_quo <= w_quo_nxt;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_result   <= w_calc_out;
        r_div_zero <= 1'b0;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: directed self-checking bench for seq_divider (XLEN=64).
// Checks reset values, DIV/DIVU/REM/REMU results and latency, zero/overflow cases,
// result backpressure, kill mid-calculation and asynchronous reset mid-calculation.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        op_signed;
  logic        op_rem;
  logic [63:0] dividend;
  logic [63:0] divisor;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        div_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(.XLEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_signed (op_signed),
    .op_rem    (op_rem),
`ifdef SEQ_DIVIDER_WORD_EN
    .word_op   (1'b0),
`endif
    .dividend  (dividend),
    .divisor   (divisor),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid; latency counts edges from accept.
  task automatic start_op(input logic s, input logic r, input logic [63:0] a, input logic [63:0] b,
                          output int lat);
    @(negedge clk);
    op_signed = s;
    op_rem    = r;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic s, input logic r,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_res, input logic exp_dz, input int exp_lat);
    int lat;
    start_op(s, r, a, b, lat);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, result, exp_res);
    check({tag, "_dz"}, 64'(div_zero), 64'(exp_dz));
    // out_ready is high, so this edge completes the handshake.
    @(posedge clk);
    #1;
    check({tag, "_idle"}, {63'd0, in_ready, out_valid} , 64'd2);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    op_signed = 1'b0;
    op_rem    = 1'b0;
    dividend  = '0;
    divisor   = '0;
    kill      = 1'b0;
    out_ready = 1'b1;
    #23;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result, 64'd0);
    check("rst_div_zero", 64'(div_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 1'b0, 65);
    run_op("remu_100_7", 1'b0, 1'b1, 64'd100, 64'd7, 64'd2, 1'b0, 65);
    run_op("div_m7_2", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65);
    run_op("rem_m7_2", 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 65);
    run_op("rem_7_m2", 1'b1, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, 65);
    run_op("div_7_m2", 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 65);
    run_op("divu_big", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0, 65);
    run_op("divu_by0", 1'b0, 1'b0, 64'd1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1);
    run_op("remu_by0", 1'b0, 1'b1, 64'd1234, 64'd0, 64'd1234, 1'b1, 1);
    run_op("div_ovf", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1'b0, 1);
    run_op("rem_ovf", 1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd0, 1'b0, 1);

    // Result backpressure: hold for 10 cycles while a competing request is offered.
    out_ready = 1'b0;
    start_op(1'b0, 1'b0, 64'd50, 64'd5, lat);
    check("bp_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 64'd999;
    divisor  = 64'd0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_res", result, 64'd10);
      check("bp_hold_rdy", {62'd0, in_ready, out_valid}, 64'd1);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release", {62'd0, in_ready, out_valid}, 64'd2);
    @(posedge clk);
    #1;
    check("bp_no_ghost", {62'd0, in_ready, out_valid}, 64'd2);
    check("bp_res_kept", result, 64'd10);

    // kill at iteration 20, with a competing in_valid in the same cycle.
    @(negedge clk);
    op_signed = 1'b0;
    op_rem    = 1'b0;
    dividend  = 64'd1000;
    divisor   = 64'd3;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("kill_busy", 64'(in_ready), 64'd0);
    kill     = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    kill     = 1'b0;
    in_valid = 1'b0;
    check("kill_idle", {62'd0, in_ready, out_valid}, 64'd2);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) seen++;
    end
    check("kill_no_result", 64'(seen), 64'd0);

    // Asynchronous reset mid-calculation, off the clock edge.
    @(negedge clk);
    dividend = 64'd77;
    divisor  = 64'd7;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd1);
    check("arst_result", result, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("divu_81_9", 1'b0, 1'b0, 64'd81, 64'd9, 64'd9, 1'b0, 65);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
